// File: rtl/gpio_bus_regs.sv
// CPU-facing register bank for gpio_one_port: direction/output registers,
// pin synchroniser, per-pin edge detection into sticky status, and a level IRQ.
module gpio_bus_regs #(
    parameter int N     = 15,
    parameter int BUS_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_addr,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [BUS_W-1:0] i_wdata,
    output logic [BUS_W-1:0] o_rdata,
    output logic [N:0]       o_data_dir,
    output logic [N:0]       o_data_transmit,
    input  logic [N:0]       i_data_received,
    output logic             o_irq
);
    localparam logic [2:0] A_DIR      = 3'd0;
    localparam logic [2:0] A_OUT      = 3'd1;
    localparam logic [2:0] A_IN       = 3'd2;
    localparam logic [2:0] A_OUT_SET  = 3'd3;
    localparam logic [2:0] A_OUT_CLR  = 3'd4;
    localparam logic [2:0] A_IRQ_EN   = 3'd5;
    localparam logic [2:0] A_IRQ_POL  = 3'd6;
    localparam logic [2:0] A_IRQ_STAT = 3'd7;

    logic [N:0]       r_dir, r_out, r_irq_en, r_irq_pol, r_irq_stat;
    logic [N:0]       r_s1, r_s2, r_s3;
    logic [1:0]       r_arm_cnt;
    logic [BUS_W-1:0] r_rdata;
    logic             r_irq;

    logic [N:0]       w_wd, w_hit, w_clr;
    logic [BUS_W-1:0] w_rd_mux;
    logic             w_armed;
    logic             w_unused;

    // Bits of i_wdata above N are architecturally ignored.
    assign w_wd     = i_wdata[N:0];
    assign w_unused = ^i_wdata;
    assign w_armed  = (r_arm_cnt == 2'd3);
    assign w_clr    = (i_we && i_addr == A_IRQ_STAT) ? w_wd : '0;

    // Only input pins can raise status, and only once the synchroniser has filled.
    generate
        for (genvar gi = 0; gi <= N; gi++) begin : g_edge
            assign w_hit[gi] = (r_irq_pol[gi] ? (r_s2[gi] & ~r_s3[gi])
                                              : (~r_s2[gi] & r_s3[gi]))
                               & ~r_dir[gi] & w_armed;
        end
    endgenerate

    always_comb begin
        w_rd_mux = '0;
        case (i_addr)
            A_DIR:      w_rd_mux[N:0] = r_dir;
            A_OUT:      w_rd_mux[N:0] = r_out;
            A_IN:       w_rd_mux[N:0] = r_s2;
            A_IRQ_EN:   w_rd_mux[N:0] = r_irq_en;
            A_IRQ_POL:  w_rd_mux[N:0] = r_irq_pol;
            A_IRQ_STAT: w_rd_mux[N:0] = r_irq_stat;
            default:    w_rd_mux      = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dir      <= '0;
            r_out      <= '0;
            r_irq_en   <= '0;
            r_irq_pol  <= '0;
            r_irq_stat <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_arm_cnt  <= '0;
            r_rdata    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_s1 <= i_data_received;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (r_arm_cnt != 2'd3) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
            end
            if (i_we) begin
                case (i_addr)
                    A_DIR:     r_dir     <= w_wd;
                    A_OUT:     r_out     <= w_wd;
                    A_OUT_SET: r_out     <= r_out | w_wd;
                    A_OUT_CLR: r_out     <= r_out & ~w_wd;
                    A_IRQ_EN:  r_irq_en  <= w_wd;
                    A_IRQ_POL: r_irq_pol <= w_wd;
                    default:   ;
                endcase
            end
            // A new hit overrides a simultaneous write-1-to-clear.
            r_irq_stat <= (r_irq_stat & ~w_clr) | w_hit;
            r_irq      <= |(r_irq_stat & r_irq_en);
            if (i_re) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign o_rdata         = r_rdata;
    assign o_data_dir      = r_dir;
    assign o_data_transmit = r_out;
    assign o_irq           = r_irq;
endmodule

// File: tb/tb_gpio_bus_regs.sv
// Directed bench for gpio_bus_regs: register access, synchroniser latency,
// edge/IRQ timing, arm blanking, W1C/set priority and reset during an access.
module tb_gpio_bus_regs;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [2:0]  i_addr;
    logic        i_we, i_re;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic [15:0] o_data_dir, o_data_transmit;
    logic [15:0] i_data_received;
    logic        o_irq;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] sb_q[$];

    gpio_bus_regs #(.N(15), .BUS_W(32)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_addr          (i_addr),
        .i_we            (i_we),
        .i_re            (i_re),
        .i_wdata         (i_wdata),
        .o_rdata         (o_rdata),
        .o_data_dir      (o_data_dir),
        .o_data_transmit (o_data_transmit),
        .i_data_received (i_data_received),
        .o_irq           (o_irq)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge i_clk);
    endtask

    // All tasks are entered at a negedge and return at a later negedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        i_we = 1'b1; i_addr = a; i_wdata = d;
        @(negedge i_clk);
        i_we = 1'b0;
        $display("wr addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        i_re = 1'b1; i_addr = a;
        sb_q.push_back(exp);
        @(negedge i_clk);
        i_re = 1'b0;
        $display("rd addr=%0d data=0x%08h", a, o_rdata);
        chk(tag, o_rdata, sb_q.pop_front());
    endtask

    task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp,
                      input string tag);
        i_we = 1'b1; i_re = 1'b1; i_addr = a; i_wdata = d;
        sb_q.push_back(exp);
        @(negedge i_clk);
        i_we = 1'b0; i_re = 1'b0;
        $display("rw addr=%0d wdata=0x%08h rdata=0x%08h", a, d, o_rdata);
        chk(tag, o_rdata, sb_q.pop_front());
    endtask

    initial begin
        i_rst = 1'b1; i_addr = '0; i_we = 1'b0; i_re = 1'b0;
        i_wdata = '0; i_data_received = '0;
        repeat (3) cyc();
        chk("rst_dir", {16'h0, o_data_dir}, 32'h0);
        chk("rst_out", {16'h0, o_data_transmit}, 32'h0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_irq", {31'h0, o_irq}, 32'h0);
        i_rst = 1'b0;
        cyc();

        // Basic RW; upper bus bits are dropped.
        wr(3'd0, 32'hFFFF_FFFF);
        chk("dir_out", {16'h0, o_data_dir}, 32'h0000_FFFF);
        wr(3'd1, 32'h0000_AAAA);
        chk("out_out", {16'h0, o_data_transmit}, 32'h0000_AAAA);
        rd(3'd0, 32'h0000_FFFF, "rd_dir");
        rd(3'd1, 32'h0000_AAAA, "rd_out");

        // Set/clear aliases and read-during-write.
        wr(3'd1, 32'h0000_00F0);
        wr(3'd3, 32'h0000_000F);
        rd(3'd1, 32'h0000_00FF, "out_set");
        wr(3'd4, 32'h0000_0030);
        rd(3'd1, 32'h0000_00CF, "out_clr");
        chk("tx_cf", {16'h0, o_data_transmit}, 32'h0000_00CF);
        rd(3'd3, 32'h0, "rd_set_zero");
        rd(3'd4, 32'h0, "rd_clr_zero");
        rw(3'd1, 32'h0000_1111, 32'h0000_00CF, "rw_prewrite");
        rd(3'd1, 32'h0000_1111, "rw_postwrite");
        wr(3'd2, 32'h0000_FFFF);
        rd(3'd2, 32'h0, "in_ro");

        // Synchroniser latency; output pins ignored for status.
        wr(3'd6, 32'h0000_FFFF);
        wr(3'd0, 32'h0000_00FF);
        i_data_received = 16'h75FF;
        cyc();
        rd(3'd2, 32'h0, "in_early");
        rd(3'd2, 32'h0000_75FF, "in_sync");
        rd(3'd7, 32'h0000_7500, "stat_inputs_only");
        chk("irq_not_en", {31'h0, o_irq}, 32'h0);
        wr(3'd5, 32'h0000_0100);
        cyc();
        chk("irq_en_hi", {31'h0, o_irq}, 32'h1);
        i_data_received = 16'h0000;
        repeat (4) cyc();
        wr(3'd7, 32'h0000_FFFF);
        cyc();
        rd(3'd7, 32'h0, "stat_w1c_all");
        chk("irq_cleared", {31'h0, o_irq}, 32'h0);
        wr(3'd0, 32'h0);

        // Rising edge on pin0: STAT at k+2, IRQ at k+3.
        wr(3'd6, 32'h0000_0001);
        wr(3'd5, 32'h0000_0001);
        i_data_received = 16'h0001;
        cyc();
        cyc();
        chk("irq_k1", {31'h0, o_irq}, 32'h0);
        rd(3'd7, 32'h0, "stat_k2_pre");
        chk("irq_k2", {31'h0, o_irq}, 32'h0);
        rd(3'd7, 32'h0000_0001, "stat_k3");
        chk("irq_k3", {31'h0, o_irq}, 32'h1);
        wr(3'd7, 32'h0000_0001);
        chk("irq_lag", {31'h0, o_irq}, 32'h1);
        cyc();
        chk("irq_drop", {31'h0, o_irq}, 32'h0);
        i_data_received = 16'h0000;
        repeat (4) cyc();
        chk("irq_fall_none", {31'h0, o_irq}, 32'h0);
        rd(3'd7, 32'h0, "stat_fall_none");

        // Arm blanking after reset with pins high and rising polarity.
        i_data_received = 16'hFFFF;
        i_rst = 1'b1;
        repeat (3) cyc();
        i_rst = 1'b0;
        wr(3'd6, 32'h0000_FFFF);
        repeat (6) cyc();
        rd(3'd7, 32'h0, "arm_blank");

        // Hit and W1C on the same edge: set wins.
        i_data_received = 16'hFFFE;
        repeat (4) cyc();
        rd(3'd7, 32'h0, "pol_fall_ignored");
        i_data_received = 16'hFFFF;
        cyc();
        cyc();
        wr(3'd7, 32'h0000_0001);
        rd(3'd7, 32'h0000_0001, "set_wins");

        // Reset during a write.
        wr(3'd5, 32'h0000_0001);
        cyc();
        chk("irq_pre_rst", {31'h0, o_irq}, 32'h1);
        wr(3'd1, 32'h0000_5555);
        rd(3'd1, 32'h0000_5555, "rd_pre_rst");
        i_rst = 1'b1; i_we = 1'b1; i_re = 1'b1; i_addr = 3'd1; i_wdata = 32'h0000_1234;
        cyc();
        i_rst = 1'b0; i_we = 1'b0; i_re = 1'b0;
        $display("rst+wr addr=1 data=0x00001234 dropped");
        chk("rst_mid_out", {16'h0, o_data_transmit}, 32'h0);
        chk("rst_mid_rdata", o_rdata, 32'h0);
        chk("rst_mid_irq", {31'h0, o_irq}, 32'h0);
        rd(3'd7, 32'h0, "rst_mid_stat");
        rd(3'd1, 32'h0, "rst_mid_rd_out");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/gpio_bus_regs.md
Name: gpio_bus_regs

Overview:
- Bus-side register stage that sits directly upstream of gpio_one_port.
- Decodes CPU load/store accesses from the MIPS-based core.
- Holds the direction and output-data registers that drive gpio_one_port.
- Synchronises the port's received data and detects per-pin edges into a sticky interrupt status register with a level interrupt output.

Parameters:
- N, 15: MSB index of the GPIO port; port width is N+1 (max 31).
- BUS_W, 32: CPU data bus width. Register bits above N read as 0 and ignore writes.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_addr  in  3  word index of the register (see map).
- i_we  in  1  write strobe, one cycle per access.
- i_re  in  1  read strobe, one cycle per access.
- i_wdata  in  BUS_W  write data.
- o_rdata  out  BUS_W  read data, registered.
- o_data_dir  out  N+1  to gpio_one_port i_data_dir (1 = output, 0 = input).
- o_data_transmit  out  N+1  to gpio_one_port i_data_transmit.
- i_data_received  in  N+1  from gpio_one_port o_data_received; asynchronous to i_clk.
- o_irq  out  1  level interrupt, registered.

Behaviour:
- Register map (i_addr):
  - 0 DIR: RW.
  - 1 OUT: RW.
  - 2 IN: RO; returns the synchronised pins.
  - 3 OUT_SET: WO; OUT |= wdata.
  - 4 OUT_CLR: WO; OUT &= ~wdata.
  - 5 IRQ_EN: RW.
  - 6 IRQ_POL: RW; 1 = rising edge, 0 = falling edge.
  - 7 IRQ_STAT: read; write-1-to-clear.
- Reads of OUT_SET and OUT_CLR return 0. Writes to IN are ignored.
- o_data_dir = DIR and o_data_transmit = OUT, both driven directly from the registers. A write takes effect on the outputs the cycle after the strobe.
- Read latency is 1: i_re sampled at edge k, so o_rdata is valid after edge k and held until the next i_re. o_rdata does not update without i_re.
- Simultaneous i_we and i_re to the same address: the write is performed and the read returns the pre-write value.
- Synchroniser: three-stage chain s1 <= i_data_received, s2 <= s1, s3 <= s2. IN reads s2.
- Edge detection, per bit b:
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - hit = (POL ? rise : fall) & ~DIR & armed.
  - Output pins (DIR = 1) never set status.
- Status: STAT[b] <= (STAT[b] & ~clr[b]) | hit[b], where clr = wdata on a write to address 7. When hit and clear coincide, set wins.
- Status sets regardless of IRQ_EN. o_irq <= |(STAT & IRQ_EN), registered, so it lags STAT by one cycle.
- Latency: a pin change stable before edge k reaches s2 at k+1, STAT at k+2 and o_irq at k+3.
- Arm counter: 2-bit counter, cleared by reset, increments each cycle and saturates at 3. armed = (count == 3). This blocks spurious edges while the synchroniser chain fills after reset.
- Changing POL or DIR does not alter existing STAT bits.
- Reset values, all 0: DIR (all pins inputs), OUT, IRQ_EN, IRQ_POL, IRQ_STAT, s1, s2, s3, arm counter, o_rdata, o_irq.
- Reset mid-operation (i_rst high during a strobe): reset wins and the access is dropped.
- Reset takes effect on the edge where i_rst is sampled high, whether or not i_we or i_re are active.

Test Plan:
- Reset, then write DIR = 0xFFFF, OUT = 0xAAAA → o_data_dir = 0xFFFF and o_data_transmit = 0xAAAA one cycle after each write; read DIR gives o_rdata = 0x0000FFFF the cycle after i_re.
- OUT = 0x00F0; write OUT_SET = 0x000F, then OUT_CLR = 0x0030 → OUT reads 0x00FF, then 0x00CF; OUT_SET and OUT_CLR read 0.
- DIR = 0x00FF, i_data_received = 0x7500 stable → IN reads 0x7500 no earlier than 2 cycles after the change. Bits 7:0 ignore pin activity for STAT.
- DIR = 0, POL = 0x0001, EN = 0x0001, pin0 0→1 before edge k → STAT = 0x0001 at k+2 and o_irq = 1 at k+3. Write 1 to STAT bit0 → STAT = 0 and o_irq drops the next cycle. A 1→0 change on pin0 sets nothing.
- Pins held at 0xFFFF through reset release → STAT stays 0 (arm blanking). Then a W1C of bit0 in the same cycle as a new hit on bit0 leaves STAT bit0 = 1.
- Assert i_rst during a write of OUT = 0x1234 → OUT = 0, o_rdata = 0, o_irq = 0 and STAT = 0 the next cycle.
